// File: rtl/asgn_binop_seq.sv
`default_nettype none
// =============================================================================
// asgn_binop_seq : sequential "acc op= b" unit with a restoring divider
// Revision: 1.0
// =============================================================================
module asgn_binop_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic [WIDTH-1:0] acc
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_MOD  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_SSHL = 4'd10;
  localparam logic [3:0] OP_SSHR = 4'd11;
  localparam logic [3:0] OP_LOAD = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXEC   = 2'd1,
    S_DIVIDE = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_err_q, out_err_d;

  logic [WIDTH-1:0] exec_res;
  logic             exec_err;
  logic [WIDTH:0]   rem_shift;
  logic             div_fits;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] div_res;
  logic             in_is_div;

  // Single-cycle datapath. Native SV shifts already return 0 once the
  // amount reaches WIDTH, which gives the required saturation for b >= WIDTH.
  always_comb begin
    exec_res = acc_q;
    exec_err = 1'b0;
    case (op_q)
      OP_ADD:          exec_res = acc_q + b_q;
      OP_SUB:          exec_res = acc_q - b_q;
      OP_MUL:          exec_res = acc_q * b_q;
      OP_DIV, OP_MOD:  exec_res = acc_q;
      OP_AND:          exec_res = acc_q & b_q;
      OP_OR:           exec_res = acc_q | b_q;
      OP_XOR:          exec_res = acc_q ^ b_q;
      OP_SHL, OP_SSHL: exec_res = acc_q << b_q;
      OP_SHR, OP_SSHR: exec_res = acc_q >> b_q;
      OP_LOAD:         exec_res = b_q;
      default:         exec_err = 1'b1;
    endcase
  end

  // One restoring-division step; with b = 0 every step "fits", so the
  // quotient fills with ones and the remainder collects the dividend.
  always_comb begin
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    div_fits  = (rem_shift >= {1'b0, b_q});
    quo_step  = {quo_q[WIDTH-2:0], div_fits};
    rem_step  = div_fits ? WIDTH'(rem_shift - {1'b0, b_q}) : rem_shift[WIDTH-1:0];
    div_res   = (op_q == OP_DIV) ? quo_step : rem_step;
  end

  assign in_is_div = (in_op == OP_DIV) || (in_op == OP_MOD);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    b_d         = b_q;
    op_d        = op_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          b_d  = in_b;
          op_d = in_op;
          if (in_is_div) begin
            state_d = S_DIVIDE;
            quo_d   = acc_q;
            rem_d   = '0;
            cnt_d   = '0;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        acc_d       = exec_res;
        state_d     = S_RESP;
        out_valid_d = 1'b1;
        out_data_d  = exec_res;
        out_err_d   = exec_err;
      end
      S_DIVIDE: begin
        quo_d = quo_step;
        rem_d = rem_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          acc_d       = div_res;
          state_d     = S_RESP;
          out_valid_d = 1'b1;
          out_data_d  = div_res;
          out_err_d   = 1'b0;
        end
      end
      S_RESP: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          out_data_d  = '0;
          out_err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      b_q         <= '0;
      op_q        <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      b_q         <= b_d;
      op_q        <= op_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;
  assign acc       = acc_q;

endmodule
`default_nettype wire

// File: tb/tb_asgn_binop_seq.sv
`default_nettype none
// =============================================================================
// tb_asgn_binop_seq : directed self-checking bench for asgn_binop_seq (WIDTH=4)
// Revision: 1.0
// =============================================================================
module tb_asgn_binop_seq;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;
  logic [WIDTH-1:0] acc;

  int n_checks = 0;
  int n_fail   = 0;

  asgn_binop_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .acc       (acc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [3:0] b;
    logic [3:0] exp;
    int         lat;
    logic       err;
    int         hold;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic add(input logic [3:0] op, input logic [3:0] b, input logic [3:0] exp,
                     input int lat, input logic err, input int hold);
    vec_t v;
    v.op = op; v.b = b; v.exp = exp; v.lat = lat; v.err = err; v.hold = hold;
    vecs.push_back(v);
  endtask

  // Issue one command, measure accept-to-out_valid latency (accept edge = 1),
  // optionally stall the result for `hold` cycles, then complete the handshake.
  task automatic run_cmd(input string tag, input vec_t v);
    int   lat;
    int   guard;
    logic [3:0] held;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check({tag, " ready"}, in_ready, 1);
    in_valid = 1'b1; in_op = v.op; in_b = v.b;
    @(posedge clk); #1;
    // Scramble inputs after accept: the DUT must use the latched command.
    in_valid = 1'b0; in_op = 4'd12; in_b = 4'hA;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, lat, v.lat);
    check({tag, " data"}, out_data, v.exp);
    check({tag, " err"}, out_err, v.err);
    check({tag, " acc"}, acc, v.exp);
    held = out_data;
    if (v.hold > 0) begin
      // Offer a competing command while the result is stalled.
      in_valid = 1'b1; in_op = 4'd12; in_b = 4'd0;
      for (int k = 0; k < v.hold; k++) begin
        @(posedge clk); #1;
        check({tag, " hold valid"}, out_valid, 1);
        check({tag, " hold data"}, out_data, held);
        check({tag, " hold ready"}, in_ready, 0);
      end
      in_valid = 1'b0;
      check({tag, " hold acc"}, acc, v.exp);
    end
    out_ready = 1'b1;
    #1;
    check({tag, " ready in handshake"}, in_ready, 0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " post valid"}, out_valid, 0);
    check({tag, " post data"}, out_data, 0);
    check({tag, " post err"}, out_err, 0);
    check({tag, " post ready"}, in_ready, 1);
  endtask

  initial begin
    int seen;
    vec_t v;
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_b = '0; out_ready = 1'b0;
    #1;
    check("reset acc", acc, 0);
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 0);
    check("reset out_err", out_err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset in_ready", in_ready, 1);

    // op, b, expected acc, latency, err, hold
    add(12, 5, 5, 2, 0, 0);  add(0, 3, 8, 2, 0, 0);
    add(12, 2, 2, 2, 0, 0);  add(1, 5, 13, 2, 0, 0);
    add(12, 7, 7, 2, 0, 0);  add(2, 3, 5, 2, 0, 4);
    add(12, 13, 13, 2, 0, 0); add(3, 3, 4, 5, 0, 0);
    add(12, 13, 13, 2, 0, 0); add(4, 3, 1, 5, 0, 0);
    add(12, 13, 13, 2, 0, 0); add(3, 0, 15, 5, 0, 0);
    add(12, 13, 13, 2, 0, 0); add(4, 0, 13, 5, 0, 0);
    add(12, 3, 3, 2, 0, 0);  add(8, 5, 0, 2, 0, 0);
    add(12, 12, 12, 2, 0, 0); add(11, 2, 3, 2, 0, 0);
    add(12, 9, 9, 2, 0, 0);  add(8, 1, 2, 2, 0, 0);
    add(12, 12, 12, 2, 0, 0); add(9, 4, 0, 2, 0, 0);
    add(12, 13, 13, 2, 0, 0); add(10, 3, 8, 2, 0, 0);
    add(12, 12, 12, 2, 0, 0); add(5, 10, 8, 2, 0, 0);
    add(6, 3, 11, 2, 0, 0);  add(7, 6, 13, 2, 0, 0);
    add(12, 6, 6, 2, 0, 0);  add(14, 1, 6, 2, 1, 0);

    foreach (vecs[i]) begin
      v = vecs[i];
      run_cmd($sformatf("v%0d op%0d b%0d", i, v.op, v.b), v);
    end

    // Reset in the middle of a division: result must be discarded.
    v.op = 12; v.b = 13; v.exp = 13; v.lat = 2; v.err = 0; v.hold = 0;
    run_cmd("rst pre-load", v);
    in_valid = 1'b1; in_op = 4'd3; in_b = 4'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst async acc", acc, 0);
    check("rst async out_valid", out_valid, 0);
    check("rst async out_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst in_ready after release", in_ready, 1);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    check("rst no result emitted", seen, 0);
    check("rst acc stays cleared", acc, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
